// File: rtl/rrf_mp_pkg.sv
// Shared defaults and ring-tag arithmetic for the rename register file.
package rrf_mp_pkg;

    localparam int unsigned RRF_DATA_LEN = 32;
    localparam int unsigned RRF_NUM_DEF  = 64;
    localparam int unsigned RRF_SEL_DEF  = $clog2(RRF_NUM_DEF);

    // Forward distance from b to a on a ring of num entries; num is a power of two.
    function automatic int unsigned tag_dist(input int unsigned a, input int unsigned b,
                                             input int unsigned num);
        return (a - b) & (num - 1);
    endfunction

endpackage

// File: rtl/rrf_alloc_ptr.sv
// Circular allocator: free/commit pointers, free count, stall and flush recovery.
module rrf_alloc_ptr
    import rrf_mp_pkg::*;
#(
    parameter int unsigned RRF_NUM = RRF_NUM_DEF,
    parameter int unsigned RRF_SEL = $clog2(RRF_NUM),
    parameter int unsigned ALLOC_W = 2,
    parameter int unsigned COM_W   = 2
)(
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [$clog2(ALLOC_W+1)-1:0] i_alloc_num,
    input  logic [$clog2(COM_W+1)-1:0]   i_com_num,
    input  logic                         i_flush,
    input  logic [RRF_SEL-1:0]           i_flush_tag,
    output logic [ALLOC_W*RRF_SEL-1:0]   o_alloc_tag,
    output logic [COM_W*RRF_SEL-1:0]     o_com_tag,
    output logic                         o_stall,
    output logic                         o_grant,
    output logic [RRF_SEL:0]             o_freenum
);

    logic [RRF_SEL-1:0] r_freeptr;
    logic [RRF_SEL-1:0] r_comptr;
    logic [RRF_SEL:0]   r_freenum;
    logic [RRF_SEL-1:0] w_comptr_next;
    logic [RRF_SEL:0]   w_freenum_next;
    logic [RRF_SEL:0]   w_flush_free;

    assign o_stall       = (RRF_SEL+1)'(i_alloc_num) > r_freenum;
    assign o_grant       = !o_stall && !i_flush && (i_alloc_num != '0);
    assign w_comptr_next = r_comptr + RRF_SEL'(i_com_num);
    // Entries still in flight after the flush are those from the post-commit comptr up to flush_tag.
    assign w_flush_free  = (RRF_SEL+1)'(RRF_NUM - tag_dist(int'(i_flush_tag), int'(w_comptr_next), RRF_NUM));
    assign o_freenum     = r_freenum;

    always_comb begin
        w_freenum_next = r_freenum + (RRF_SEL+1)'(i_com_num);
        if (o_grant)
            w_freenum_next = w_freenum_next - (RRF_SEL+1)'(i_alloc_num);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_freeptr <= '0;
            r_comptr  <= '0;
            r_freenum <= (RRF_SEL+1)'(RRF_NUM);
        end else begin
            r_comptr <= w_comptr_next;
            if (i_flush) begin
                r_freeptr <= i_flush_tag;
                r_freenum <= w_flush_free;
            end else begin
                if (o_grant)
                    r_freeptr <= r_freeptr + RRF_SEL'(i_alloc_num);
                r_freenum <= w_freenum_next;
            end
        end
    end

    for (genvar i = 0; i < ALLOC_W; i++) begin : g_alloc
        assign o_alloc_tag[i*RRF_SEL +: RRF_SEL] = r_freeptr + RRF_SEL'(i);
    end

    for (genvar c = 0; c < COM_W; c++) begin : g_com
        assign o_com_tag[c*RRF_SEL +: RRF_SEL] = r_comptr + RRF_SEL'(c);
    end

    a_com_bound: assert property (@(posedge clk_i) disable iff (!reset_i)
        (RRF_SEL+1)'(i_com_num) <= (RRF_SEL+1)'(RRF_NUM) - r_freenum);

endmodule

// File: rtl/rrf_mp.sv
// Multi-port rename register file: data/valid arrays, bypassed operand reads,
// writeback decode, and commit readout; pointer bookkeeping lives in rrf_alloc_ptr.
module rrf_mp
    import rrf_mp_pkg::*;
#(
    parameter int unsigned DATA_LEN = RRF_DATA_LEN,
    parameter int unsigned RRF_NUM  = RRF_NUM_DEF,
    parameter int unsigned RRF_SEL  = $clog2(RRF_NUM),
    parameter int unsigned RD_PORTS = 4,
    parameter int unsigned WB_PORTS = 3,
    parameter int unsigned ALLOC_W  = 2,
    parameter int unsigned COM_W    = 2
)(
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [RD_PORTS*RRF_SEL-1:0]  rd_tag_i,
    output logic [RD_PORTS*DATA_LEN-1:0] rd_data_o,
    output logic [RD_PORTS-1:0]          rd_valid_o,
    input  logic [WB_PORTS-1:0]          wb_we_i,
    input  logic [WB_PORTS*RRF_SEL-1:0]  wb_tag_i,
    input  logic [WB_PORTS*DATA_LEN-1:0] wb_data_i,
    input  logic [$clog2(ALLOC_W+1)-1:0] alloc_num_i,
    output logic [ALLOC_W*RRF_SEL-1:0]   alloc_tag_o,
    output logic                         stall_o,
    input  logic [$clog2(COM_W+1)-1:0]   com_num_i,
    output logic [COM_W*DATA_LEN-1:0]    com_data_o,
    output logic [COM_W*RRF_SEL-1:0]     com_tag_o,
    input  logic                         flush_i,
    input  logic [RRF_SEL-1:0]           flush_tag_i,
    output logic [RRF_SEL:0]             freenum_o
);

    logic [DATA_LEN-1:0] r_data [RRF_NUM];
    logic [RRF_NUM-1:0]  r_valid;
    logic                w_grant;

    rrf_alloc_ptr #(
        .RRF_NUM (RRF_NUM),
        .RRF_SEL (RRF_SEL),
        .ALLOC_W (ALLOC_W),
        .COM_W   (COM_W)
    ) u_ptr (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .i_alloc_num (alloc_num_i),
        .i_com_num   (com_num_i),
        .i_flush     (flush_i),
        .i_flush_tag (flush_tag_i),
        .o_alloc_tag (alloc_tag_o),
        .o_com_tag   (com_tag_o),
        .o_stall     (stall_o),
        .o_grant     (w_grant),
        .o_freenum   (freenum_o)
    );

    // Ports are visited highest first so a duplicated tag keeps the lowest port's data.
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < WB_PORTS; k++) begin
            if (wb_we_i[WB_PORTS-1-k])
                r_data[wb_tag_i[(WB_PORTS-1-k)*RRF_SEL +: RRF_SEL]]
                    <= wb_data_i[(WB_PORTS-1-k)*DATA_LEN +: DATA_LEN];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_valid <= '0;
        end else begin
            for (int unsigned k = 0; k < WB_PORTS; k++) begin
                if (wb_we_i[k])
                    r_valid[wb_tag_i[k*RRF_SEL +: RRF_SEL]] <= 1'b1;
            end
            // Allocation clears come last so they override a same-cycle writeback.
            for (int unsigned i = 0; i < ALLOC_W; i++) begin
                if (w_grant && (i < int'(alloc_num_i)))
                    r_valid[alloc_tag_o[i*RRF_SEL +: RRF_SEL]] <= 1'b0;
            end
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [RRF_SEL-1:0]  w_tag;
        logic [DATA_LEN-1:0] w_data;
        logic                w_hit;

        assign w_tag = rd_tag_i[p*RRF_SEL +: RRF_SEL];

        always_comb begin
            w_data = r_data[w_tag];
            w_hit  = r_valid[w_tag];
            for (int unsigned k = 0; k < WB_PORTS; k++) begin
                if (wb_we_i[WB_PORTS-1-k] &&
                    (wb_tag_i[(WB_PORTS-1-k)*RRF_SEL +: RRF_SEL] == w_tag)) begin
                    w_data = wb_data_i[(WB_PORTS-1-k)*DATA_LEN +: DATA_LEN];
                    w_hit  = 1'b1;
                end
            end
        end

        assign rd_data_o[p*DATA_LEN +: DATA_LEN] = w_data;
        assign rd_valid_o[p]                     = w_hit;
    end

    for (genvar c = 0; c < COM_W; c++) begin : g_com
        assign com_data_o[c*DATA_LEN +: DATA_LEN] = r_data[com_tag_o[c*RRF_SEL +: RRF_SEL]];
    end

endmodule

// File: tb/tb_rrf_mp.sv
// Directed bench for rrf_mp: allocator vector table plus hand sequences for bypass, flush and reset.
module tb_rrf_mp;

    localparam int DL  = 32;
    localparam int NUM = 64;
    localparam int SEL = 6;
    localparam int RDP = 4;
    localparam int WBP = 3;
    localparam int AW  = 2;
    localparam int CW  = 2;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [RDP*SEL-1:0] rd_tag_i;
    logic [RDP*DL-1:0]  rd_data_o;
    logic [RDP-1:0]     rd_valid_o;
    logic [WBP-1:0]     wb_we_i;
    logic [WBP*SEL-1:0] wb_tag_i;
    logic [WBP*DL-1:0]  wb_data_i;
    logic [1:0]         alloc_num_i;
    logic [AW*SEL-1:0]  alloc_tag_o;
    logic               stall_o;
    logic [1:0]         com_num_i;
    logic [CW*DL-1:0]   com_data_o;
    logic [CW*SEL-1:0]  com_tag_o;
    logic               flush_i;
    logic [SEL-1:0]     flush_tag_i;
    logic [SEL:0]       freenum_o;

    int n_checks = 0;
    int n_fail   = 0;

    rrf_mp #(
        .DATA_LEN (DL),
        .RRF_NUM  (NUM),
        .RRF_SEL  (SEL),
        .RD_PORTS (RDP),
        .WB_PORTS (WBP),
        .ALLOC_W  (AW),
        .COM_W    (CW)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rd_tag_i    (rd_tag_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .wb_we_i     (wb_we_i),
        .wb_tag_i    (wb_tag_i),
        .wb_data_i   (wb_data_i),
        .alloc_num_i (alloc_num_i),
        .alloc_tag_o (alloc_tag_o),
        .stall_o     (stall_o),
        .com_num_i   (com_num_i),
        .com_data_o  (com_data_o),
        .com_tag_o   (com_tag_o),
        .flush_i     (flush_i),
        .flush_tag_i (flush_tag_i),
        .freenum_o   (freenum_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]     alloc;
        logic [1:0]     com;
        logic           stall;
        logic [SEL-1:0] tag0;
        logic [SEL-1:0] tag1;
        logic [SEL-1:0] ctag0;
        logic [SEL:0]   freenum;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_wb(input int p, input logic [SEL-1:0] tag, input logic [DL-1:0] d);
        wb_we_i[p]            = 1'b1;
        wb_tag_i[p*SEL +: SEL] = tag;
        wb_data_i[p*DL +: DL]  = d;
    endtask

    task automatic set_rd(input int p, input logic [SEL-1:0] tag);
        rd_tag_i[p*SEL +: SEL] = tag;
    endtask

    function automatic logic [DL-1:0] rdd(input int p);
        return rd_data_o[p*DL +: DL];
    endfunction

    function automatic logic [SEL-1:0] atag(input int s);
        return alloc_tag_o[s*SEL +: SEL];
    endfunction

    function automatic logic [SEL-1:0] ctag(input int s);
        return com_tag_o[s*SEL +: SEL];
    endfunction

    function automatic logic [DL-1:0] cdat(input int s);
        return com_data_o[s*DL +: DL];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // state after fill: freeptr=0 comptr=0 freenum=0
        vecs[0] = '{2'd1, 2'd0, 1'b1, 6'd0, 6'd1, 6'd0, 7'd0};
        vecs[1] = '{2'd0, 2'd0, 1'b0, 6'd0, 6'd1, 6'd0, 7'd0};
        vecs[2] = '{2'd0, 2'd2, 1'b0, 6'd0, 6'd1, 6'd0, 7'd0};
        vecs[3] = '{2'd2, 2'd0, 1'b0, 6'd0, 6'd1, 6'd2, 7'd2};
        vecs[4] = '{2'd0, 2'd2, 1'b0, 6'd2, 6'd3, 6'd2, 7'd0};
        vecs[5] = '{2'd2, 2'd1, 1'b0, 6'd2, 6'd3, 6'd4, 7'd2};
        vecs[6] = '{2'd2, 2'd0, 1'b1, 6'd4, 6'd5, 6'd5, 7'd1};
        vecs[7] = '{2'd1, 2'd0, 1'b0, 6'd4, 6'd5, 6'd5, 7'd1};
        vecs[8] = '{2'd0, 2'd0, 1'b0, 6'd5, 6'd6, 6'd5, 7'd0};

        reset_i     = 1'b0;
        rd_tag_i    = '0;
        wb_we_i     = '0;
        wb_tag_i    = '0;
        wb_data_i   = '0;
        alloc_num_i = '0;
        com_num_i   = '0;
        flush_i     = 1'b0;
        flush_tag_i = '0;
        set_rd(0, 6'd0); set_rd(1, 6'd1); set_rd(2, 6'd2); set_rd(3, 6'd3);
        tick();
        tick();

        check("reset_freenum", freenum_o, 64);
        check("reset_stall", stall_o, 0);
        check("reset_atag0", atag(0), 0);
        check("reset_atag1", atag(1), 1);
        check("reset_ctag0", ctag(0), 0);
        check("reset_ctag1", ctag(1), 1);
        check("reset_rd_valid", rd_valid_o, 0);
        reset_i = 1'b1;

        // first allocation of two
        tick();
        alloc_num_i = 2'd2;
        #1;
        check("alloc2_tag0", atag(0), 0);
        check("alloc2_tag1", atag(1), 1);
        check("alloc2_stall", stall_o, 0);
        tick();
        alloc_num_i = 2'd0;
        #1;
        check("alloc2_freenum", freenum_o, 62);
        check("alloc2_valid01", rd_valid_o[1:0], 0);

        // same-cycle bypass and array readback
        set_wb(1, 6'd5, 32'hDEADBEEF);
        set_wb(0, 6'd0, 32'h11111111);
        set_wb(2, 6'd1, 32'h22222222);
        set_rd(0, 6'd5); set_rd(1, 6'd0); set_rd(3, 6'd7);
        #1;
        check("byp_data", rdd(0), 32'hDEADBEEF);
        check("byp_valid", rd_valid_o[0], 1);
        check("byp_data_p1", rdd(1), 32'h11111111);
        check("byp_valid_p3", rd_valid_o[3], 0);
        tick();
        wb_we_i = '0;
        #1;
        check("arr_data", rdd(0), 32'hDEADBEEF);
        check("arr_valid", rd_valid_o[0], 1);
        check("com_data0", cdat(0), 32'h11111111);
        check("com_data1", cdat(1), 32'h22222222);

        // duplicate writeback tag: port 0 beats port 2
        set_wb(0, 6'd7, 32'hAAAA0000);
        set_wb(2, 6'd7, 32'hBBBB0000);
        #1;
        check("dup_byp_data", rdd(3), 32'hAAAA0000);
        tick();
        wb_we_i = '0;
        #1;
        check("dup_arr_data", rdd(3), 32'hAAAA0000);

        // fill the file: freeptr 2 -> 0, freenum 62 -> 0
        for (int i = 0; i < 31; i++) begin
            alloc_num_i = 2'd2;
            #1;
            check("fill_tag0", atag(0), (2 + 2 * i) % NUM);
            check("fill_freenum", freenum_o, 62 - 2 * i);
            tick();
        end
        alloc_num_i = 2'd0;

        for (int v = 0; v < 9; v++) begin
            alloc_num_i = vecs[v].alloc;
            com_num_i   = vecs[v].com;
            #1;
            check("vec_stall", stall_o, vecs[v].stall);
            check("vec_tag0", atag(0), vecs[v].tag0);
            check("vec_tag1", atag(1), vecs[v].tag1);
            check("vec_ctag0", ctag(0), vecs[v].ctag0);
            check("vec_freenum", freenum_o, vecs[v].freenum);
            tick();
        end
        alloc_num_i = 2'd0;

        // drain commits: comptr 5 -> 59 -> 60
        for (int i = 0; i < 27; i++) begin
            com_num_i = 2'd2;
            #1;
            check("drain_ctag0", ctag(0), 5 + 2 * i);
            check("drain_freenum", freenum_o, 2 * i);
            tick();
        end
        com_num_i = 2'd1;
        tick();
        com_num_i = 2'd0;

        // flush to tag 4 with comptr 60: 8 in flight; allocation ignored
        flush_i = 1'b1; flush_tag_i = 6'd4; alloc_num_i = 2'd2;
        tick();
        flush_i = 1'b0; alloc_num_i = 2'd0;
        #1;
        check("fl4_freeptr", atag(0), 4);
        check("fl4_comptr", ctag(0), 60);
        check("fl4_freenum", freenum_o, 56);

        // flush to 62 while committing one
        flush_i = 1'b1; flush_tag_i = 6'd62; com_num_i = 2'd1; alloc_num_i = 2'd1;
        tick();
        flush_i = 1'b0; com_num_i = 2'd0; alloc_num_i = 2'd0;
        #1;
        check("fl62_freeptr", atag(0), 62);
        check("fl62_comptr", ctag(0), 61);
        check("fl62_freenum", freenum_o, 63);

        // flush onto the post-commit comptr: file empty
        flush_i = 1'b1; flush_tag_i = 6'd62; com_num_i = 2'd1;
        tick();
        flush_i = 1'b0; com_num_i = 2'd0;
        #1;
        check("flempty_comptr", ctag(0), 62);
        check("flempty_freenum", freenum_o, 64);

        flush_i = 1'b1; flush_tag_i = 6'd3;
        tick();
        flush_i = 1'b0;
        #1;
        check("fl3_freeptr", atag(0), 3);
        check("fl3_freenum", freenum_o, 59);

        // allocation beats a same-cycle writeback to the same tag
        set_wb(2, 6'd3, 32'h33);
        set_rd(2, 6'd3);
        tick();
        wb_we_i = '0;
        #1;
        check("pre_alloc_valid3", rd_valid_o[2], 1);
        check("pre_alloc_data3", rdd(2), 32'h33);
        alloc_num_i = 2'd1;
        set_wb(0, 6'd3, 32'h44);
        #1;
        check("aw_tag0", atag(0), 3);
        check("aw_stall", stall_o, 0);
        tick();
        alloc_num_i = 2'd0; wb_we_i = '0;
        #1;
        check("aw_valid3", rd_valid_o[2], 0);
        check("aw_freenum", freenum_o, 58);

        // asynchronous reset mid-cycle
        set_wb(1, 6'd10, 32'hA);
        set_rd(0, 6'd3); set_rd(1, 6'd10); set_rd(2, 6'd5); set_rd(3, 6'd0);
        tick();
        wb_we_i = '0;
        #1;
        check("pre_rst_valid10", rd_valid_o[1], 1);
        alloc_num_i = 2'd2;
        #2;
        reset_i = 1'b0;
        #1;
        check("arst_freenum", freenum_o, 64);
        check("arst_freeptr", atag(0), 0);
        check("arst_comptr", ctag(0), 0);
        check("arst_rd_valid", rd_valid_o, 0);
        alloc_num_i = 2'd0;
        tick();
        reset_i = 1'b1;
        tick();
        check("post_rst_freenum", freenum_o, 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
